// File: rtl/cu_dispatch.sv
// Two-stage compute-instruction issue: E1 decode/read, E2 writeback for MUL/SHF, hazard stall, sticky status.
// Optional stall cycle counter enabled by defining CU_DISPATCH_STALL_CNT_EN.
module cu_dispatch #(
  parameter int RF_DATASIZE   = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int SIGNAL_WIDTH  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  output logic [ADDRESS_WIDTH-1:0] ps_rf_xA,
  output logic [ADDRESS_WIDTH-1:0] ps_rf_yA,
  output logic [ADDRESS_WIDTH-1:0] ps_rf_wrtA,
  output logic [SIGNAL_WIDTH-1:0]  ps_xb_cuEn,
  output logic                     ps_xb_dmEn,
  output logic                     ps_alu_en,
  output logic [1:0]               ps_alu_cls,
  output logic                     ps_mul_en,
  output logic                     ps_mul_otreg,
  output logic [3:0]               ps_mul_dtsts,
  output logic [1:0]               ps_mul_cls,
  output logic                     ps_shf_en,
  output logic [1:0]               ps_shf_cls,
  input  logic                     mul_ps_ov,
  input  logic                     mul_ps_mn,
  input  logic                     shf_ovflag,
  input  logic                     shf_zeroflag,
  output logic [3:0]               astat,
  input  logic                     astat_clr,
  output logic [15:0]              stall_cnt
);
  localparam logic [1:0] U_ALU = 2'b00, U_MUL = 2'b01, U_SHF = 2'b10, U_DM = 2'b11;

  logic [1:0]               in_unit;
  logic [ADDRESS_WIDTH-1:0] in_rn, in_rx, in_ry;
  logic                     conflict, accept;

  logic                     v1_q, v1_d, v2_q, v2_d, ot1_q, ot1_d, mul2_q, mul2_d;
  logic [1:0]               unit1_q, unit1_d, cls1_q, cls1_d;
  logic [3:0]               dts1_q, dts1_d, astat_q, astat_d;
  logic [ADDRESS_WIDTH-1:0] rn1_q, rn1_d, rx1_q, rx1_d, ry1_q, ry1_d, rn2_q, rn2_d;
  logic                     e1_alu, e1_mul, e1_shf, e1_dm, e1_ms, e2_mul, e2_shf;

  logic unused_ok;
  assign unused_ok = (^in_instr[10:0]) ^ (RF_DATASIZE == 0);

  assign in_unit = in_instr[31:30];
  assign in_rn   = in_instr[29:26];
  assign in_rx   = in_instr[25:22];
  assign in_ry   = in_instr[21:18];

  assign e1_alu = v1_q && (unit1_q == U_ALU);
  assign e1_mul = v1_q && (unit1_q == U_MUL);
  assign e1_shf = v1_q && (unit1_q == U_SHF);
  assign e1_dm  = v1_q && (unit1_q == U_DM);
  assign e1_ms  = e1_mul || e1_shf;
  assign e2_mul = v2_q && mul2_q;
  assign e2_shf = v2_q && !mul2_q;

  // A MUL/SHF in E1 writes next cycle from E2: E1 writers would collide, readers of rn would be stale.
  assign conflict = e1_ms && ((in_unit == U_ALU) || (in_unit == U_DM) ||
                              (in_rx == rn1_q) || (in_ry == rn1_q));
  assign in_ready = !conflict;
  assign accept   = in_valid && in_ready;

  always_comb begin
    v1_d    = accept;
    unit1_d = unit1_q;
    rn1_d   = rn1_q;
    rx1_d   = rx1_q;
    ry1_d   = ry1_q;
    cls1_d  = cls1_q;
    dts1_d  = dts1_q;
    ot1_d   = ot1_q;
    if (accept) begin
      unit1_d = in_unit;
      rn1_d   = in_rn;
      rx1_d   = in_rx;
      ry1_d   = in_ry;
      cls1_d  = in_instr[17:16];
      dts1_d  = in_instr[15:12];
      ot1_d   = in_instr[11];
    end
    v2_d   = e1_ms;
    mul2_d = e1_ms ? e1_mul : mul2_q;
    rn2_d  = e1_ms ? rn1_q : rn2_q;
    // Clear first, then OR in this cycle's flags so a same-cycle set survives.
    astat_d = (astat_clr ? 4'b0000 : astat_q) |
              {e2_shf & shf_zeroflag, e2_shf & shf_ovflag, e2_mul & mul_ps_mn, e2_mul & mul_ps_ov};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      unit1_q <= U_ALU;
      rn1_q   <= '0;
      rx1_q   <= '0;
      ry1_q   <= '0;
      cls1_q  <= 2'b00;
      dts1_q  <= 4'h0;
      ot1_q   <= 1'b0;
      v2_q    <= 1'b0;
      mul2_q  <= 1'b0;
      rn2_q   <= '0;
      astat_q <= 4'h0;
    end else begin
      v1_q    <= v1_d;
      unit1_q <= unit1_d;
      rn1_q   <= rn1_d;
      rx1_q   <= rx1_d;
      ry1_q   <= ry1_d;
      cls1_q  <= cls1_d;
      dts1_q  <= dts1_d;
      ot1_q   <= ot1_d;
      v2_q    <= v2_d;
      mul2_q  <= mul2_d;
      rn2_q   <= rn2_d;
      astat_q <= astat_d;
    end
  end

  assign ps_rf_xA     = (v1_q && !e1_dm) ? rx1_q : '0;
  assign ps_rf_yA     = (v1_q && !e1_dm) ? ry1_q : '0;
  assign ps_rf_wrtA   = (e1_alu || e1_dm) ? rn1_q : (v2_q ? rn2_q : '0);
  assign ps_xb_cuEn   = {e2_mul, e2_shf, e1_alu};
  assign ps_xb_dmEn   = e1_dm;
  assign ps_alu_en    = e1_alu;
  assign ps_alu_cls   = e1_alu ? cls1_q : 2'b00;
  assign ps_mul_en    = e1_mul;
  assign ps_mul_otreg = e1_mul & ot1_q;
  assign ps_mul_dtsts = e1_mul ? dts1_q : 4'h0;
  assign ps_mul_cls   = e1_mul ? cls1_q : 2'b00;
  assign ps_shf_en    = e1_shf;
  assign ps_shf_cls   = e1_shf ? cls1_q : 2'b00;
  assign astat        = astat_q;

`ifdef CU_DISPATCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= 16'h0000;
    else     stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif
endmodule

// File: doc/cu_dispatch.md
# cu_dispatch

Two-stage issue block between the program sequencer's instruction fetch and the compute unit top. It accepts one compute instruction per cycle over a valid/ready handshake and decodes it into the multiplier, shifter, crossbar and register-file controls that the compute unit consumes. It sequences writeback for the units with registered results and stalls upstream on read-after-write and write-port hazards. It also accumulates sticky arithmetic status from the unit flags.

## Interface
- RF_DATASIZE, 16: register-file data width; used only for documentation consistency.
- ADDRESS_WIDTH, 4: register address width.
- SIGNAL_WIDTH, 3: crossbar write-source one-hot width. bit0 = ALU, bit1 = SHF, bit2 = MUL.

Ports (the clock is `clk`; reset is asynchronous and active-high, port `rst`):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  compute instruction.
- ps_rf_xA, ps_rf_yA  out  ADDRESS_WIDTH  read addresses (E1).
- ps_rf_wrtA  out  ADDRESS_WIDTH  write address (writing stage).
- ps_xb_cuEn  out  SIGNAL_WIDTH  one-hot write source; 0 = no unit write.
- ps_xb_dmEn  out  1  write DM data into the register file.
- ps_alu_en  out  1  ALU enable.
- ps_alu_cls  out  2  ALU operation class.
- ps_mul_en, ps_mul_otreg  out  1  multiplier enable and output-register select.
- ps_mul_dtsts  out  4  multiplier data format.
- ps_mul_cls  out  2  multiplier operation class.
- ps_shf_en  out  1  shifter enable.
- ps_shf_cls  out  2  shifter operation class.
- mul_ps_ov, mul_ps_mn, shf_ovflag, shf_zeroflag  in  1  unit flags.
- astat  out  4  sticky status {shf_zero, shf_ov, mul_mn, mul_ov}.
- astat_clr  in  1  synchronous clear of astat.
- stall_cnt  out  16  stall cycle count (see Configuration).

## Operation
- Instruction fields:
  - [31:30] unit: 00 ALU, 01 MUL, 10 SHF, 11 DM-load.
  - [29:26] rn.
  - [25:22] rx.
  - [21:18] ry.
  - [17:16] cls.
  - [15:12] dtsts (MUL only).
  - [11] otreg (MUL only).
  - [10:0] reserved and ignored.
- Stage E1 (register, valid bit v1) drives the read addresses and the unit enable and class.
  - ALU and DM-load write in E1: wrtA = rn, with cuEn bit0 or dmEn asserted.
  - MUL and SHF move to E2.
- Stage E2 (register, valid bit v2) holds MUL/SHF only. It drives wrtA = rn and cuEn bit2 (MUL) or bit1 (SHF).
- ALU, MUL and SHF read rx and ry. DM-load reads nothing; xA and yA are driven 0.
- Hazard: when E1 holds a valid MUL/SHF instruction with write register rn_E1, the candidate at the input conflicts if either holds:
  - it is ALU or DM-load (write-port collision);
  - it reads rn_E1 (RAW).
- in_ready = !conflict. This is combinational from in_instr and E1 state, and independent of downstream.
- On conflict, E1 loads a bubble (v1 = 0) and the candidate is held by upstream.
- Back-to-back non-conflicting instructions issue at full rate. This includes MUL then MUL with no dependency, and MUL then SHF.
- Every control output is 0 when its stage is invalid. wrtA follows the writing stage; at most one stage writes per cycle by construction.
- Flags are sampled at the end of a MUL or SHF E2 cycle and ORed into astat; only the flags of the unit in E2 are sampled.
- astat_clr clears astat. If a clear and a set occur in the same cycle, the set wins.

## Timing
- Reset: v1 = v2 = 0, all outputs 0, astat = 0, stall_cnt = 0. in_ready = 1 from the first cycle after reset.
- Accept at edge k:
  - the instruction is in E1 during cycle k+1;
  - ALU/DM write commits at edge k+2;
  - MUL/SHF is in E2 during cycle k+2, and its write and flag capture commit at edge k+3.
- A dependent instruction after MUL/SHF incurs exactly 1 bubble.
- Reset asserted mid-operation squashes E1 and E2 immediately (asynchronous); no write is issued.
- in_valid = 0 inserts a bubble with no side effects.

## Configuration
- CU_DISPATCH_STALL_CNT_EN defined:
  - stall_cnt increments on every cycle with in_valid && !in_ready;
  - it saturates at 16'hFFFF;
  - it is cleared only by rst.
- Not defined: the counter logic is absent and stall_cnt is tied to 0.

## Test plan
- ALU rn = 3 accepted at edge 1 -> cycle 2: ps_alu_en = 1, wrtA = 3, cuEn = 3'b001; cycle 3: all controls 0.
- MUL rn = 5 with rx = 1, ry = 2, then MUL rn = 6 with rx = 5 -> in_ready = 0 for 1 cycle and E1 bubble. The second MUL's E1 shows xA = 5 in the same cycle that wrtA = 6 is not yet driven, i.e. the cycle after the first MUL's E2 writes rn = 5 with cuEn = 3'b100. stall_cnt = 1 with the macro.
- SHF rn = 2 followed by DM-load rn = 7 -> 1 stall cycle, then dmEn = 1 and wrtA = 7, never in the same cycle as cuEn = 3'b010.
- MUL rn = 4 followed by an independent SHF rn = 8 reading rx = 1, ry = 9 -> no stall; E2 writes 4 while E1 drives shf_en and xA = 1.
- mul_ps_ov = 1 in the MUL E2 cycle -> astat = 4'b0001 sticky; astat_clr alone -> 0; clear with a simultaneous shf_zeroflag in SHF E2 -> 4'b1000.
- rst pulsed while a MUL is in E2 -> cuEn, wrtA and astat are 0 immediately and no write occurs afterwards.
